// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if -- producer handshakes plus the FIFO write port, bundled
// so that the arbiter and its environment connect through one port.
//
//   req_valid    [N_REQ]         per-producer data valid
//   req_data     [N_REQ*DATA_W]  producer i data in [i*DATA_W +: DATA_W]
//   req_ready    [N_REQ]         per-producer accept, one-hot or zero
//   fifo_full    1               FIFO full flag (backpressure)
//   fifo_wr_en   1               FIFO write enable
//   fifo_wr_data [DATA_W]        FIFO write data
//
// master: the arbiter. slave: the producers and the FIFO.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    fifo_full;
    logic                    fifo_wr_en;
    logic [DATA_W-1:0]       fifo_wr_data;

    modport master (
        input  req_valid, req_data, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data
    );

    modport slave (
        output req_valid, req_data, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter -- round-robin arbiter sharing one FIFO write port among
// N_REQ producers. A grantee keeps the port for up to BURST beats, or until
// its valid drops. fifo_full stalls the grant without releasing it.
//
//   clk       in   FIFO write clock, rising edge
//   rst       in   asynchronous, active-high reset
//   bus       --   producer handshakes and FIFO write port (master side)
//   grant_id  out  index of the current or last grantee, registered
//   busy      out  high while a grant is held
module fifo_wr_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int BURST  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_wr_arbiter_if.master        bus,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     busy
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BURST + 1);

    // Reset value of last makes requester 0 the first winner.
    localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST - 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state, state_next;
    logic [ID_W-1:0]    last, last_next, grant_next;
    logic [CNT_W-1:0]   beat_cnt, cnt_next;
    logic [ID_W-1:0]    pick, idx;
    logic               found;
    logic               xfer;
    logic [DATA_W-1:0]  slice [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign slice[g] = bus.req_data[g*DATA_W +: DATA_W];
    end

    // Round-robin search: first valid requester after last, wrapping.
    always_comb begin
        found = 1'b0;
        pick  = last;
        idx   = last;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = ID_W'((int'(last) + k) % N_REQ);
            if (!found && bus.req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next       = state;
        grant_next       = grant_id;
        last_next        = last;
        cnt_next         = beat_cnt;
        xfer             = 1'b0;
        bus.req_ready    = '0;
        bus.fifo_wr_en   = 1'b0;
        bus.fifo_wr_data = slice[grant_id];

        case (state)
            IDLE: begin
                if (found) begin
                    state_next = GRANT;
                    grant_next = pick;
                    last_next  = pick;
                    cnt_next   = '0;
                end
            end
            GRANT: begin
                // A full FIFO only withholds ready; it never ends the grant.
                bus.req_ready[grant_id] = !bus.fifo_full;
                xfer                    = bus.req_valid[grant_id] && !bus.fifo_full;
                bus.fifo_wr_en          = xfer;
                if (xfer) begin
                    cnt_next = beat_cnt + CNT_W'(1);
                end
                if ((xfer && beat_cnt == CNT_LAST) || !bus.req_valid[grant_id]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            last     <= LAST_RST;
            beat_cnt <= '0;
        end else begin
            state    <= state_next;
            grant_id <= grant_next;
            last     <= last_next;
            beat_cnt <= cnt_next;
        end
    end

    assign busy = (state == GRANT);
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter -- directed bench for fifo_wr_arbiter (N_REQ=4,
// DATA_W=8, BURST=4). Inputs change 1 time unit after a rising edge and
// outputs are compared 1 unit later, well before the next edge.
module tb_fifo_wr_arbiter;
    localparam int N_REQ  = 4;
    localparam int DATA_W = 8;
    localparam int BURST  = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant_id;
    logic       busy;
    int         vectors     = 0;
    int         miscompares = 0;
    int         writes;

    fifo_wr_arbiter_if #(.N_REQ(N_REQ), .DATA_W(DATA_W)) bus ();

    fifo_wr_arbiter #(.N_REQ(N_REQ), .DATA_W(DATA_W), .BURST(BURST)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int i, input logic [7:0] v);
        bus.req_data[i*DATA_W +: DATA_W] = v;
    endtask

    // Compare all visible outputs; data only matters while wr_en is high.
    task automatic chk(input string tag, input logic b, input logic [1:0] g,
                       input logic [3:0] r, input logic w, input logic [7:0] d);
        check({tag, ".busy"},  32'(busy),           32'(b));
        check({tag, ".grant"}, 32'(grant_id),       32'(g));
        check({tag, ".ready"}, 32'(bus.req_ready),  32'(r));
        check({tag, ".wr_en"}, 32'(bus.fifo_wr_en), 32'(w));
        if (w) check({tag, ".data"}, 32'(bus.fifo_wr_data), 32'(d));
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.fifo_full = 1'b0;
        settle();
        chk("reset", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        check("reset.last", 32'(dut.last), 32'd3);
        check("reset.cnt",  32'(dut.beat_cnt), 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Single producer 2, three beats then valid low.
        bus.req_valid = 4'b0100;
        set_data(2, 8'h11);
        settle();
        chk("t1.idle", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        tick(); settle();
        chk("t1.b1", 1'b1, 2'd2, 4'b0100, 1'b1, 8'h11);
        tick(); set_data(2, 8'h22); settle();
        chk("t1.b2", 1'b1, 2'd2, 4'b0100, 1'b1, 8'h22);
        tick(); set_data(2, 8'h33); settle();
        chk("t1.b3", 1'b1, 2'd2, 4'b0100, 1'b1, 8'h33);
        tick(); bus.req_valid = 4'b0000; settle();
        chk("t1.drop", 1'b1, 2'd2, 4'b0100, 1'b0, 8'h00);
        tick(); settle();
        chk("t1.rel", 1'b0, 2'd2, 4'h0, 1'b0, 8'h00);

        // All four valid: order 0,1,2,3,0, four beats each, one idle gap.
        rst = 1'b1; settle(); rst = 1'b0;
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'hA0 + 8'(i));
        bus.req_valid = 4'b1111;
        settle();
        chk("t2.c0", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        writes = 0;
        for (int c = 1; c <= 21; c++) begin
            logic [1:0] g;
            logic       b;
            tick(); settle();
            g = 2'(((c - 1) / 5) % 4);
            b = (c % 5) != 0;
            chk($sformatf("t2.c%0d", c), b, g, b ? (4'b0001 << g) : 4'h0, b, 8'hA0 + 8'(g));
            if (c <= 20 && bus.fifo_wr_en) writes++;
        end
        check("t2.writes", 32'(writes), 32'd16);
        tick(); bus.req_valid = 4'b0000; settle();
        chk("t2.drop", 1'b1, 2'd0, 4'b0001, 1'b0, 8'h00);
        tick(); settle();
        chk("t2.rel", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);

        // Producer 1 with fifo_full for three cycles after beat 2.
        bus.req_valid = 4'b0010;
        set_data(1, 8'hB1);
        settle();
        chk("t3.idle", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        tick(); settle();
        chk("t3.b1", 1'b1, 2'd1, 4'b0010, 1'b1, 8'hB1);
        tick(); set_data(1, 8'hB2); settle();
        chk("t3.b2", 1'b1, 2'd1, 4'b0010, 1'b1, 8'hB2);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (i == 0) begin
                set_data(1, 8'hB3);
                bus.fifo_full = 1'b1;
            end
            settle();
            chk($sformatf("t3.full%0d", i), 1'b1, 2'd1, 4'h0, 1'b0, 8'h00);
            check($sformatf("t3.full%0d.cnt", i), 32'(dut.beat_cnt), 32'd2);
        end
        tick(); bus.fifo_full = 1'b0; settle();
        chk("t3.b3", 1'b1, 2'd1, 4'b0010, 1'b1, 8'hB3);
        tick(); set_data(1, 8'hB4); settle();
        chk("t3.b4", 1'b1, 2'd1, 4'b0010, 1'b1, 8'hB4);
        check("t3.b4.cnt", 32'(dut.beat_cnt), 32'd3);
        tick(); bus.req_valid = 4'b0000; settle();
        chk("t3.rel", 1'b0, 2'd1, 4'h0, 1'b0, 8'h00);

        // Producer 0 drops after two beats while producer 3 waits.
        bus.req_valid = 4'b0001;
        set_data(0, 8'hD0);
        settle();
        chk("t4.idle", 1'b0, 2'd1, 4'h0, 1'b0, 8'h00);
        tick(); bus.req_valid = 4'b1001; set_data(3, 8'hD3); settle();
        chk("t4.b1", 1'b1, 2'd0, 4'b0001, 1'b1, 8'hD0);
        tick(); set_data(0, 8'hD1); settle();
        chk("t4.b2", 1'b1, 2'd0, 4'b0001, 1'b1, 8'hD1);
        tick(); bus.req_valid = 4'b1000; settle();
        chk("t4.drop", 1'b1, 2'd0, 4'b0001, 1'b0, 8'h00);
        tick(); settle();
        chk("t4.gap", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        tick(); settle();
        chk("t4.g3", 1'b1, 2'd3, 4'b1000, 1'b1, 8'hD3);
        tick(); bus.req_valid = 4'b0000; settle();
        chk("t4.g3drop", 1'b1, 2'd3, 4'b1000, 1'b0, 8'h00);
        tick(); settle();
        chk("t4.rel", 1'b0, 2'd3, 4'h0, 1'b0, 8'h00);

        // Reset pulsed mid-burst of producer 2; without it producer 3 would win next.
        bus.req_valid = 4'b0100;
        set_data(2, 8'hE1);
        settle();
        chk("t5.idle", 1'b0, 2'd3, 4'h0, 1'b0, 8'h00);
        tick(); settle();
        chk("t5.b1", 1'b1, 2'd2, 4'b0100, 1'b1, 8'hE1);
        tick(); set_data(2, 8'hE2); settle();
        chk("t5.b2", 1'b1, 2'd2, 4'b0100, 1'b1, 8'hE2);
        rst = 1'b1; settle();
        chk("t5.rst", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        check("t5.rst.last", 32'(dut.last), 32'd3);
        check("t5.rst.cnt",  32'(dut.beat_cnt), 32'd0);
        for (int i = 0; i < N_REQ; i++) set_data(i, 8'hF0 + 8'(i));
        bus.req_valid = 4'b1111;
        rst = 1'b0;
        settle();
        chk("t5.post", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);
        tick(); settle();
        chk("t5.g0", 1'b1, 2'd0, 4'b0001, 1'b1, 8'hF0);
        bus.req_valid = 4'b0000;
        tick(); tick(); settle();
        chk("t5.end", 1'b0, 2'd0, 4'h0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
